bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared 4-master system bus.
- Takes active-low requests from masters 0-3 and produces the active-low grants (m0_grnt_..m3_grnt_) that steer the bus master multiplexer.
- Exactly one grant is asserted at all times. When nobody requests, the grant stays parked on the last owner.
- An optional hold limit pre-empts an owner that keeps the bus while others wait, but only in an idle bus cycle.

Parameters:
- MAX_HOLD, 16: consecutive owner cycles allowed while another master is requesting before forced rotation. 0 disables pre-emption.
- HOLD_W, 5: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_  input  1  reset, asynchronous, active-low.
- m0_req_  input  1  master 0 bus request, active-low.
- m1_req_  input  1  master 1 bus request, active-low.
- m2_req_  input  1  master 2 bus request, active-low.
- m3_req_  input  1  master 3 bus request, active-low.
- s_as_  input  1  address strobe as driven onto the shared bus, active-low. `ENABLE_ means an access is in flight.
- m0_grnt_  output  1  master 0 grant, active-low, registered.
- m1_grnt_  output  1  master 1 grant, active-low, registered.
- m2_grnt_  output  1  master 2 grant, active-low, registered.
- m3_grnt_  output  1  master 3 grant, active-low, registered.
- owner  output  2  index of the current bus owner, registered.
- preempt  output  1  one-cycle active-high pulse in the cycle after a forced rotation.

Behaviour:
- Reset (reset_ = 0, asynchronous):
  - owner = 0; m0_grnt_ = `ENABLE_; m1/m2/m3_grnt_ = `DISABLE_.
  - hold_cnt = 0; preempt = 0.
  - Outputs hold these values for the whole time reset_ is low, including a reset applied mid-transfer.
- Grant encoding: grant of owner n is `ENABLE_, all others `DISABLE_. One-hot-low is invariant in every cycle.
- Next-owner search (combinational): scan owner+1, owner+2, owner+3 (mod 4) and take the first with req_ = `ENABLE_. If none is found, the candidate is owner itself.
- Per-cycle decision, evaluated in priority order:
  1. Release: current owner's req_ = `DISABLE_ and another master requests. Owner becomes the search result next edge; hold_cnt clears.
  2. Park: current owner's req_ = `DISABLE_ and no other master requests. Owner unchanged; hold_cnt clears.
  3. Contended hold: owner requesting and at least one other master requesting.
     - hold_cnt increments, saturating at MAX_HOLD.
     - If MAX_HOLD != 0, hold_cnt = MAX_HOLD and s_as_ = `DISABLE_: owner becomes the search result excluding the current owner. hold_cnt clears; preempt = 1 next cycle.
     - If s_as_ = `ENABLE_, pre-emption is deferred; hold_cnt stays at MAX_HOLD until an idle cycle.
  4. Uncontended hold: owner requesting, nobody else requesting. hold_cnt clears.
- Latency: a request granted on a release appears on the grant outputs one clock after the owner deasserts req_. Worst-case wait with all four requesting and holding is 3 × (MAX_HOLD + 1) cycles plus idle-cycle deferral.
- Simultaneous release and multiple new requests: the round-robin order from owner+1 decides. Masters that are not requesting are never granted except by parking.
- preempt is 0 in every cycle not following a forced rotation.
- Requests are level-sensitive. No latching: a request withdrawn before being granted is forgotten.
- Grants change only on clk edges. No combinational path from req_ or s_as_ to any output.

Test Plan:
- Reset, then all req_ = 1 for 5 cycles -> m0_grnt_ = 0, others 1, owner = 0 throughout; preempt = 0.
- From owner = 0: m0_req_ = 1, m2_req_ = 0 and m3_req_ = 0 in the same cycle -> next edge owner = 2, m2_grnt_ = 0; after m2 releases, owner = 3.
- Owner = 3 releases while m0_req_ = 0 and m1_req_ = 0 -> wrap-around gives owner = 0, not 1.
- MAX_HOLD = 4: m1 holds with s_as_ = 1, m2 requesting continuously -> after 4 contended cycles, owner = 2 on the next edge; preempt = 1 for exactly one cycle.
- Same as the previous case but s_as_ = 0 for 3 extra cycles at saturation -> rotation deferred until the first cycle with s_as_ = 1, then owner = 2.
- Assert reset_ = 0 asynchronously while owner = 2 and s_as_ = 0 -> grants return to m0 immediately, before the next edge; hold_cnt = 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface bus_arbiter_if;
    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       s_as_;
    logic       m0_grnt_;
    logic       m1_grnt_;
    logic       m2_grnt_;
    logic       m3_grnt_;
    logic [1:0] owner;
    logic       preempt;

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
    );

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 4-master bus: active-low requests in, one-hot-low
// registered grants out, parking on the last owner and optional idle-cycle pre-emption.
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic          clk,
    input  logic          reset_,
    bus_arbiter_if.slave  bus
);

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    logic [3:0]        reqVec;
    logic [1:0]        owner_q,   owner_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              preempt_q, preempt_d;
    logic [3:0]        grnt_q,    grnt_d;

    logic              ownerReq;
    logic              othersReq;
    logic              holdFull;
    logic              busIdle;
    logic [1:0]        candidate;
    logic              candFound;
    logic [1:0]        scanIdx;

    assign reqVec = {bus.m3_req_ == ENABLE_, bus.m2_req_ == ENABLE_,
                     bus.m1_req_ == ENABLE_, bus.m0_req_ == ENABLE_};

    always_comb begin
        ownerReq  = reqVec[owner_q];
        othersReq = |(reqVec & ~(4'b0001 << owner_q));
        holdFull  = (MAX_HOLD != 0) && (holdCnt_q == HOLD_W'(MAX_HOLD));
        busIdle   = (bus.s_as_ == DISABLE_);
    end

    // Scan owner+1..owner+3 with 2-bit wrap; the owner itself is the fallback.
    always_comb begin
        candidate = owner_q;
        candFound = 1'b0;
        scanIdx   = owner_q;
        for (int k = 1; k < 4; k++) begin
            scanIdx = owner_q + 2'(k);
            if (!candFound && reqVec[scanIdx]) begin
                candidate = scanIdx;
                candFound = 1'b1;
            end
        end
    end

    always_comb begin
        owner_d   = owner_q;
        holdCnt_d = holdCnt_q;
        preempt_d = 1'b0;

        if (!ownerReq) begin
            holdCnt_d = '0;
            if (othersReq) begin
                owner_d = candidate;
            end
        end else if (othersReq) begin
            if (holdFull && busIdle) begin
                owner_d   = candidate;
                holdCnt_d = '0;
                preempt_d = 1'b1;
            end else if (holdCnt_q != HOLD_W'(MAX_HOLD)) begin
                holdCnt_d = holdCnt_q + HOLD_W'(1);
            end
        end else begin
            holdCnt_d = '0;
        end

        grnt_d = ~(4'b0001 << owner_d);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_q   <= 2'd0;
            holdCnt_q <= '0;
            preempt_q <= 1'b0;
            grnt_q    <= 4'b1110;
        end else begin
            owner_q   <= owner_d;
            holdCnt_q <= holdCnt_d;
            preempt_q <= preempt_d;
            grnt_q    <= grnt_d;
        end
    end

    assign bus.m0_grnt_ = grnt_q[0];
    assign bus.m1_grnt_ = grnt_q[1];
    assign bus.m2_grnt_ = grnt_q[2];
    assign bus.m3_grnt_ = grnt_q[3];
    assign bus.owner    = owner_q;
    assign bus.preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (MAX_HOLD = 4): directed vector table, hand-written
// pre-emption / deferral / async-reset sequences, then randomized traffic against a model.
module tb_bus_arbiter;

    localparam int MAXH = 4;

    logic clk;
    logic reset_;
    int   checks;
    int   failures;

    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(3)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] reqN;
        logic       sas;
        logic [1:0] expOwner;
        logic       expPre;
    } vec_t;

    vec_t vecs[13];

    int mOwner;
    int mHold;
    bit mPre;

    task automatic modelReset();
        mOwner = 0;
        mHold  = 0;
        mPre   = 1'b0;
    endtask

    // Spec rules expressed directly over integers: release, park, contended, uncontended.
    task automatic modelStep(input logic [3:0] reqN, input logic sas);
        bit req[4];
        bit others;
        bit found;
        int cand;
        for (int i = 0; i < 4; i++) req[i] = (reqN[i] == 1'b0);
        others = 1'b0;
        for (int i = 0; i < 4; i++) if (i != mOwner && req[i]) others = 1'b1;
        cand  = mOwner;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (!found && req[(mOwner + k) % 4]) begin
                cand  = (mOwner + k) % 4;
                found = 1'b1;
            end
        end
        mPre = 1'b0;
        if (!req[mOwner]) begin
            if (others) mOwner = cand;
            mHold = 0;
        end else if (others) begin
            if (MAXH != 0 && mHold == MAXH && sas) begin
                mOwner = cand;
                mHold  = 0;
                mPre   = 1'b1;
            end else if (mHold < MAXH) begin
                mHold = mHold + 1;
            end
        end else begin
            mHold = 0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqN, input logic sas);
        bus.m0_req_ = reqN[0];
        bus.m1_req_ = reqN[1];
        bus.m2_req_ = reqN[2];
        bus.m3_req_ = reqN[3];
        bus.s_as_   = sas;
        modelStep(reqN, sas);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expOwner, input logic expPre);
        logic [3:0] gotGrnt;
        logic [3:0] expGrnt;
        gotGrnt = {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_};
        expGrnt = 4'b1111 & ~(4'b0001 << expOwner);
        checks++;
        if (bus.owner !== expOwner) begin
            failures++;
            $display("[TB] FAIL %s owner: got %0d expected %0d", name, bus.owner, expOwner);
        end
        checks++;
        if (gotGrnt !== expGrnt) begin
            failures++;
            $display("[TB] FAIL %s grants: got %b expected %b", name, gotGrnt, expGrnt);
        end
        checks++;
        if (bus.preempt !== expPre) begin
            failures++;
            $display("[TB] FAIL %s preempt: got %b expected %b", name, bus.preempt, expPre);
        end
    endtask

    initial begin
        logic [3:0] rq;
        logic       sa;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{4'b1111, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 2'd0, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{4'b1111, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{4'b0011, 1'b1, 2'd2, 1'b0};
        vecs[6]  = '{4'b0011, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{4'b0111, 1'b1, 2'd3, 1'b0};
        vecs[8]  = '{4'b0100, 1'b1, 2'd3, 1'b0};
        vecs[9]  = '{4'b1100, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{4'b1111, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{4'b1101, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{4'b1111, 1'b1, 2'd1, 1'b0};

        reset_      = 1'b0;
        bus.m0_req_ = 1'b1;
        bus.m1_req_ = 1'b1;
        bus.m2_req_ = 1'b1;
        bus.m3_req_ = 1'b1;
        bus.s_as_   = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 2'd0, 1'b0);
        reset_ = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].reqN, vecs[i].sas);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOwner, vecs[i].expPre);
        end

        // Owner 1 holds against m2 with an idle bus: rotation on the fifth contended edge.
        for (int c = 1; c <= MAXH; c++) begin
            applyStimulus(4'b1001, 1'b1);
            checkOutput($sformatf("hold%0d", c), 2'd1, 1'b0);
        end
        applyStimulus(4'b1001, 1'b1);
        checkOutput("preempt_rotate", 2'd2, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("preempt_pulse_end", 2'd2, 1'b0);
        applyStimulus(4'b1101, 1'b1);
        checkOutput("back_to_m1", 2'd1, 1'b0);

        // Same contention but the bus stays busy at saturation for three cycles.
        for (int c = 1; c <= MAXH; c++) begin
            applyStimulus(4'b1001, 1'b1);
            checkOutput($sformatf("dhold%0d", c), 2'd1, 1'b0);
        end
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(4'b1001, 1'b0);
            checkOutput($sformatf("deferred%0d", c), 2'd1, 1'b0);
        end
        applyStimulus(4'b1001, 1'b1);
        checkOutput("deferred_rotate", 2'd2, 1'b1);

        // Build up hold count with owner 2 mid-transfer, then reset between edges.
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(4'b1001, 1'b0);
            checkOutput($sformatf("prereset%0d", c), 2'd2, 1'b0);
        end
        #2;
        reset_ = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 2'd0, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("async_reset_across_edge", 2'd0, 1'b0);
        reset_ = 1'b1;

        // A cleared hold counter means m0 keeps the bus for exactly MAXH contended cycles.
        for (int c = 1; c <= MAXH; c++) begin
            applyStimulus(4'b1100, 1'b1);
            checkOutput($sformatf("posthold%0d", c), 2'd0, 1'b0);
        end
        applyStimulus(4'b1100, 1'b1);
        checkOutput("postreset_rotate", 2'd1, 1'b1);

        rq = 4'b1111;
        sa = 1'b1;
        for (int n = 0; n < 500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
            end
            sa = ($urandom_range(0, 2) != 0);
            applyStimulus(rq, sa);
            checkOutput($sformatf("rand%0d", n), 2'(mOwner), mPre);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
